// File: rtl/fir_smpl_sequencer.sv
// rtl/fir_smpl_sequencer.sv - ring-buffer sample queue streaming the newest TAPS stereo samples to one FIR band filter
module fir_smpl_sequencer #(
    parameter int DEPTH = 1024,
    parameter int TAPS  = 1021,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_smpl,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rght_smpl,
    input  logic        clr_ovr,
    output logic        sequencing,
    output logic [15:0] lft_out,
    output logic [15:0] rght_out,
    output logic        frame_done,
    output logic        overrun
);

    localparam int CW = $clog2(TAPS + 1);

    typedef enum logic [1:0] {FILL, IDLE, ARM, SEQ} state_t;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_fill_cnt;
    logic [CW-1:0] r_seq_cnt;
    logic          r_pending;

    logic          w_accept;
    logic          w_drop;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_rd_addr;

    // Only one sample may wait behind a running frame; anything beyond that is lost.
    assign w_accept  = wrt_smpl && !r_pending;
    assign w_drop    = wrt_smpl && r_pending;
    assign w_base    = r_wr_ptr - AW'(TAPS);
    assign w_rd_addr = (r_state == ARM) ? w_base : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {lft_smpl, rght_smpl};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill_cnt <= '0;
            r_seq_cnt  <= '0;
            r_pending  <= 1'b0;
            sequencing <= 1'b0;
            lft_out    <= '0;
            rght_out   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_fill_cnt != CW'(TAPS)) begin
                    r_fill_cnt <= r_fill_cnt + CW'(1);
                end
            end

            if (w_drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (r_state)
                FILL: begin
                    if (w_accept && r_fill_cnt == CW'(TAPS - 1)) begin
                        r_state <= ARM;
                    end
                end
                IDLE: begin
                    if (r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= ARM;
                    end else if (w_accept) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    {lft_out, rght_out} <= r_mem[w_rd_addr];
                    sequencing <= 1'b1;
                    r_rd_ptr   <= w_base + AW'(1);
                    r_seq_cnt  <= '0;
                    r_state    <= SEQ;
                    if (w_accept) begin
                        r_pending <= 1'b1;
                    end
                end
                SEQ: begin
                    if (w_accept) begin
                        r_pending <= 1'b1;
                    end
                    if (r_seq_cnt == CW'(TAPS - 1)) begin
                        sequencing <= 1'b0;
                        frame_done <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        {lft_out, rght_out} <= r_mem[w_rd_addr];
                        r_rd_ptr  <= r_rd_ptr + AW'(1);
                        r_seq_cnt <= r_seq_cnt + CW'(1);
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_smpl_sequencer.sv
// tb/tb_fir_smpl_sequencer.sv - scoreboard bench for fir_smpl_sequencer at DEPTH=8, TAPS=5
module tb_fir_smpl_sequencer;

    localparam int DEPTH = 8;
    localparam int TAPS  = 5;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt_smpl = 1'b0;
    logic [15:0] lft_smpl = '0;
    logic [15:0] rght_smpl = '0;
    logic        clr_ovr = 1'b0;
    logic        sequencing;
    logic [15:0] lft_out;
    logic [15:0] rght_out;
    logic        frame_done;
    logic        overrun;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] hist[$];
    logic [31:0] exp_q[$];
    int          run_len = 0;
    int          gap = 0;
    bit          prev_frame = 1'b0;

    fir_smpl_sequencer #(.DEPTH(DEPTH), .TAPS(TAPS), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .clr_ovr    (clr_ovr),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int v);
        logic [15:0] a;
        logic [15:0] b;
        a = v[15:0];
        b = -a;
        return {a, b};
    endfunction

    task automatic push_frame();
        for (int i = hist.size() - TAPS; i < hist.size(); i++) begin
            exp_q.push_back(hist[i]);
        end
    endtask

    // Called at a negedge; strobes for one cycle and returns at the following negedge.
    task automatic write_smpl(input int v, input bit accepted, input bit frame);
        logic [31:0] e;
        e = mk(v);
        wrt_smpl  = 1'b1;
        lft_smpl  = e[31:16];
        rght_smpl = e[15:0];
        @(negedge clk);
        wrt_smpl = 1'b0;
        if (accepted) hist.push_back(e);
        if (frame) push_frame();
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, frame_done}, 32'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            gap = 0;
            prev_frame = 1'b0;
        end else if (sequencing) begin
            if (run_len == 0 && prev_frame) check("gap_ge2", {31'd0, gap >= 2}, 32'd1);
            run_len++;
            if (exp_q.size() == 0) begin
                check("unexp_seq", {31'd0, sequencing}, 32'd0);
            end else begin
                check("data", {lft_out, rght_out}, exp_q.pop_front());
            end
        end else begin
            if (run_len != 0) begin
                check("run_len", run_len, TAPS);
                check("frame_done", {31'd0, frame_done}, 32'd1);
                prev_frame = 1'b1;
                gap = 1;
            end else begin
                check("stray_done", {31'd0, frame_done}, 32'd0);
                gap++;
            end
            run_len = 0;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_seq", {31'd0, sequencing}, 32'd0);
        check("rst_out", {lft_out, rght_out}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 1; v <= 4; v++) begin
            write_smpl(v, 1'b1, 1'b0);
            @(negedge clk);
        end
        write_smpl(5, 1'b1, 1'b1);
        check("t1_seq_low", {31'd0, sequencing}, 32'd0);
        for (int k = 0; k < TAPS; k++) begin
            @(negedge clk);
            check("seq_on", {31'd0, sequencing}, 32'd1);
        end
        @(negedge clk);
        check("done_t7", {31'd0, frame_done}, 32'd1);
        check("seq_off_t7", {31'd0, sequencing}, 32'd0);
        @(negedge clk);
        check("out_hold", {lft_out, rght_out}, mk(5));

        for (int v = 6; v <= 11; v++) begin
            write_smpl(v, 1'b1, 1'b1);
            wait_frame_done();
        end

        write_smpl(12, 1'b1, 1'b1);
        @(negedge clk);
        write_smpl(13, 1'b1, 1'b1);
        wait_frame_done();
        wait_frame_done();
        check("ovr_single_pend", {31'd0, overrun}, 32'd0);

        write_smpl(14, 1'b1, 1'b1);
        @(negedge clk);
        write_smpl(15, 1'b1, 1'b1);
        write_smpl(16, 1'b0, 1'b0);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        wait_frame_done();
        wait_frame_done();
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        write_smpl(17, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_seq", {31'd0, sequencing}, 32'd0);
        check("async_out", {lft_out, rght_out}, 32'd0);
        exp_q.delete();
        hist.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 21; v <= 24; v++) begin
            write_smpl(v, 1'b1, 1'b0);
            @(negedge clk);
        end
        write_smpl(25, 1'b1, 1'b1);
        wait_frame_done();
        repeat (4) @(negedge clk);
        check("exp_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
